core_control_fsm: RTL
=====================

CORE_CONTROL_FSM -- requirements
Module: core_control_fsm

Interface
REQ-001 Parameter: MEM_TIMEOUT, 15, max cycles held in MEMORY waiting for mem_ready before error halt (range 1..255).
REQ-002 Clock  in  1  core clock; FSM state updates on posedge (PC updates on negedge, mid-cycle).
REQ-003 peripheral_reset  in  1  reset, asynchronous, active-high.
REQ-004 start  in  1  level; leaves IDLE or PAUSE when sampled high.
REQ-005 step_mode  in  1  1 = pause after every retired instruction.
REQ-006 opcode  in  7  instruction[6:0] from instruction memory; sampled in DECODE only.
REQ-007 mem_ready  in  1  data-memory completion for load/store.
REQ-008 mem_req  out  1  data-memory request; high throughout MEMORY.
REQ-009 en_pc  out  1  PC advance enable; one-cycle pulse in WRITEBACK.
REQ-010 branch_op  out  1  branch qualifier to PC; high with en_pc when latched opcode = 7'h63.
REQ-011 reg_write  out  1  register-file write enable; one-cycle pulse in WRITEBACK.
REQ-012 state  out  3  current state encoding (debug).
REQ-013 retired_count  out  16  instructions retired since reset.
REQ-014 halted  out  1  high in HALT.
REQ-015 error  out  1  sticky; high when HALT was entered on illegal opcode or memory timeout.

Function
REQ-016 States/encoding SHALL be IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, PAUSE=6, HALT=7.
REQ-017 IDLE->FETCH when start=1; otherwise remain in IDLE.
REQ-018 FETCH->DECODE unconditionally after one cycle.
REQ-019 DECODE SHALL latch opcode into internal register; legal set = 03,13,23,33,37,63 (hex); 73 -> HALT with error=0; any other value -> HALT with error=1; legal -> EXECUTE.
REQ-020 EXECUTE -> MEMORY if latched opcode is 03 or 23, else -> WRITEBACK.
REQ-021 MEMORY: remain while mem_ready=0; -> WRITEBACK in the cycle after mem_ready is sampled 1; wait counter reset on MEMORY entry.
REQ-022 MEMORY: if MEM_TIMEOUT cycles elapse with mem_ready=0 -> HALT with error=1; mem_ready on the final permitted cycle wins over timeout.
REQ-023 WRITEBACK: en_pc=1; branch_op=1 iff opcode 63; reg_write=1 iff opcode in {03,13,33,37}; retired_count increments, saturating at 16'hFFFF.
REQ-024 WRITEBACK -> PAUSE if step_mode=1, else -> FETCH; PAUSE -> FETCH when start=1.
REQ-025 HALT is terminal; exit only via peripheral_reset; start ignored.
REQ-026 start ignored in all states except IDLE and PAUSE.
REQ-027 Latency: non-memory instruction = 4 cycles FETCH->FETCH; load/store with immediate mem_ready = 5 cycles; each extra wait cycle adds 1.
REQ-028 en_pc, branch_op, reg_write, mem_req, halted SHALL be decoded from registered state only (no input-to-output combinational path).
REQ-029 en_pc SHALL never be high for two consecutive cycles.

Reset
REQ-030 peripheral_reset high SHALL force immediately: state=IDLE, latched opcode=0, wait counter=0, retired_count=0, error=0; all outputs 0.
REQ-031 Reset mid-MEMORY SHALL drop mem_req in the same cycle, without waiting for a clock edge.
REQ-032 On reset release, FSM remains in IDLE until start=1.

Structure
REQ-033 Shared package core_ctrl_pkg SHALL hold state encoding and opcode constants (OP_LOAD, OP_IMM, OP_STORE, OP_REG, OP_LUI, OP_BRANCH, OP_SYSTEM).
REQ-034 Single module; no sub-module; MEMORY wait counter width = 8 bits.

Verification
REQ-035 Reset, start=1, opcode=13 stream, step_mode=0 -> en_pc every 4th cycle, reg_write with each, retired_count=3 after 3 instructions.
REQ-036 opcode=03, mem_ready raised after 2 wait cycles -> mem_req high 3 cycles, one en_pc and reg_write, instruction spans 7 cycles.
REQ-037 opcode=63 -> en_pc and branch_op high same cycle, reg_write=0; opcode=23 -> reg_write=0.
REQ-038 opcode=7F -> HALT, halted=1, error=1, no en_pc; start pulses ignored; opcode=73 -> halted=1, error=0.
REQ-039 MEM_TIMEOUT=4, store with mem_ready held 0 -> HALT with error=1 after 4 MEMORY cycles; reset asserted mid-MEMORY in second run -> mem_req=0 immediately, state=IDLE.
REQ-040 step_mode=1 -> PAUSE after each WRITEBACK, state=6 until start=1; retired_count preset near 16'hFFFF saturates, no wrap.

Source files
------------

// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the core control sequencer: state encoding,
// the opcode values the decoder understands, and small opcode classifiers.
package core_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEMORY    = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_PAUSE     = 3'd6,
        ST_HALT      = 3'd7
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    // Opcodes that proceed to EXECUTE (SYSTEM is recognised but halts)
    function automatic logic isLegalOp(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_IMM) || (op == OP_STORE) ||
               (op == OP_REG) || (op == OP_LUI) || (op == OP_BRANCH);
    endfunction

    // Loads and stores need a data-memory handshake
    function automatic logic isMemOp(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

    // Instructions that produce a register-file result
    function automatic logic writesReg(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_IMM) || (op == OP_REG) || (op == OP_LUI);
    endfunction

endpackage

// File: rtl/core_control_fsm.sv
// Multi-cycle core sequencer: walks each instruction through fetch, decode,
// execute, optional memory handshake and writeback, with single-step pause,
// a bounded memory wait and a terminal halt state. All control outputs are
// decoded from registered state only.
module core_control_fsm
    import core_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        peripheral_reset,
    input  logic        start,
    input  logic        step_mode,
    input  logic [6:0]  opcode,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        en_pc,
    output logic        branch_op,
    output logic        reg_write,
    output logic [2:0]  state,
    output logic [15:0] retired_count,
    output logic        halted,
    output logic        error
);

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [6:0]  opcode_q, opcode_d;
    logic [7:0]  waitCount_q, waitCount_d;
    logic [15:0] retired_q, retired_d;
    logic        error_q, error_d;

    // State and datapath registers; reset clears everything immediately
    always_ff @(posedge clock or posedge peripheral_reset) begin
        if (peripheral_reset) begin
            state_q     <= ST_IDLE;
            opcode_q    <= '0;
            waitCount_q <= '0;
            retired_q   <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            waitCount_q <= waitCount_d;
            retired_q   <= retired_d;
            error_q     <= error_d;
        end
    end

    // Next-state logic; memory wait counter restarts on each MEMORY entry
    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        waitCount_d = waitCount_q;
        retired_d   = retired_q;
        error_d     = error_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                opcode_d = opcode;
                if (isLegalOp(opcode)) begin
                    state_d = ST_EXECUTE;
                end else begin
                    state_d = ST_HALT;
                    if (opcode != OP_SYSTEM) error_d = 1'b1;
                end
            end
            ST_EXECUTE: begin
                if (isMemOp(opcode_q)) begin
                    state_d     = ST_MEMORY;
                    waitCount_d = '0;
                end else begin
                    state_d = ST_WRITEBACK;
                end
            end
            ST_MEMORY: begin
                if (mem_ready) begin
                    state_d = ST_WRITEBACK;
                end else if (waitCount_q == WAIT_LAST) begin
                    state_d = ST_HALT;
                    error_d = 1'b1;
                end else begin
                    waitCount_d = waitCount_q + 8'd1;
                end
            end
            ST_WRITEBACK: begin
                if (retired_q != 16'hFFFF) retired_d = retired_q + 16'd1;
                state_d = step_mode ? ST_PAUSE : ST_FETCH;
            end
            ST_PAUSE: begin
                if (start) state_d = ST_FETCH;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mem_req       = (state_q == ST_MEMORY);
    assign en_pc         = (state_q == ST_WRITEBACK);
    assign branch_op     = (state_q == ST_WRITEBACK) && (opcode_q == OP_BRANCH);
    assign reg_write     = (state_q == ST_WRITEBACK) && writesReg(opcode_q);
    assign halted        = (state_q == ST_HALT);
    assign error         = error_q;
    assign state         = state_q;
    assign retired_count = retired_q;

endmodule
